// File: rtl/ecdsa_sign_arbiter.sv
// ecdsa_sign_arbiter: round-robin sharing of one ecdsa_sign engine among
// N_REQ requesters, with a BUSY watchdog that resets a hung engine.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// S_IDLE    | no operation; pick next requester from ptr upward
// S_LAUNCH  | operands latched, eng_init pulsed, timer cleared
// S_BUSY    | waiting for a 0->1 edge on eng_done or the watchdog
// S_RESPOND | signature returned, resp_valid[idx] pulsed, error clear
// S_RECOVER | watchdog abort: eng_reset and resp_valid[idx] with error set
//
// Signatures are 512 bits: r in [511:256], s in [255:0].
module ecdsa_sign_arbiter #(
  parameter int N_REQ          = 4,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                   clk,
  input  logic                   master_reset_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [96*N_REQ-1:0]    req_message,
  input  logic [256*N_REQ-1:0]   req_priv_key,
  output logic [N_REQ-1:0]       gnt,
  output logic [N_REQ-1:0]       resp_valid,
  output logic                   resp_error,
  output logic [511:0]           resp_signature,
  output logic                   busy,
  output logic                   eng_init,
  output logic                   eng_reset,
  output logic [95:0]            eng_message,
  output logic [255:0]           eng_priv_key,
  input  logic [511:0]           eng_signature,
  input  logic                   eng_done
);

  localparam int IW = $clog2(N_REQ);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LAUNCH  = 3'd1,
    S_BUSY    = 3'd2,
    S_RESPOND = 3'd3,
    S_RECOVER = 3'd4
  } state_t;

  state_t         state;
  state_t         state_next;
  logic [IW-1:0]  ptr;
  logic [IW-1:0]  idx;
  logic [IW-1:0]  sel;
  logic [IW-1:0]  idx_inc;
  logic [IW:0]    cand;
  logic [IW:0]    inc_wide;
  logic           found;
  logic [TW-1:0]  timer;
  logic           done_q;
  logic           done_rise;
  logic           timed_out;

  // Only a fresh 0->1 transition of eng_done counts; a level left over from
  // a previous operation is ignored because done_q is already high.
  assign done_rise = eng_done & ~done_q;
  assign timed_out = (timer == TIMER_LAST);

  // Round-robin pick: first asserted req scanning upward from ptr, wrapping.
  always_comb begin
    cand  = '0;
    sel   = ptr;
    found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = {1'b0, ptr} + (IW+1)'(i);
      if (cand >= (IW+1)'(N_REQ)) cand = cand - (IW+1)'(N_REQ);
      if (!found && req[cand[IW-1:0]]) begin
        sel   = cand[IW-1:0];
        found = 1'b1;
      end
    end
  end

  // Successor of the serviced index, modulo N_REQ, for the pointer update.
  always_comb begin
    inc_wide = {1'b0, idx} + (IW+1)'(1);
    if (inc_wide == (IW+1)'(N_REQ)) inc_wide = '0;
    idx_inc = inc_wide[IW-1:0];
  end

  // State register.
  always_ff @(posedge clk or negedge master_reset_n) begin
    if (!master_reset_n) state <= S_IDLE;
    else                 state <= state_next;
  end

  // Next-state logic and outputs decoded from registered state only.
  always_comb begin
    state_next = state;
    gnt        = '0;
    resp_valid = '0;
    resp_error = 1'b0;
    busy       = 1'b0;
    eng_init   = 1'b0;
    case (state)
      S_IDLE: begin
        if (found) state_next = S_LAUNCH;
      end
      S_LAUNCH: begin
        busy       = 1'b1;
        gnt[idx]   = 1'b1;
        eng_init   = 1'b1;
        state_next = S_BUSY;
      end
      S_BUSY: begin
        busy     = 1'b1;
        gnt[idx] = 1'b1;
        // A done edge on the watchdog's last cycle still counts as success.
        if (done_rise)      state_next = S_RESPOND;
        else if (timed_out) state_next = S_RECOVER;
      end
      S_RESPOND: begin
        busy            = 1'b1;
        gnt[idx]        = 1'b1;
        resp_valid[idx] = 1'b1;
        state_next      = S_IDLE;
      end
      S_RECOVER: begin
        busy            = 1'b1;
        gnt[idx]        = 1'b1;
        resp_valid[idx] = 1'b1;
        resp_error      = 1'b1;
        state_next      = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Engine is held in reset for the whole block reset as well as RECOVER.
  assign eng_reset = ~master_reset_n | (state == S_RECOVER);

  // Operand latch, watchdog timer, done history, result capture and pointer.
  always_ff @(posedge clk or negedge master_reset_n) begin
    if (!master_reset_n) begin
      ptr            <= '0;
      idx            <= '0;
      timer          <= '0;
      done_q         <= 1'b0;
      eng_message    <= '0;
      eng_priv_key   <= '0;
      resp_signature <= '0;
    end else begin
      done_q <= eng_done;
      case (state)
        S_IDLE: begin
          if (found) begin
            idx          <= sel;
            eng_message  <= req_message[96*sel +: 96];
            eng_priv_key <= req_priv_key[256*sel +: 256];
          end
        end
        S_LAUNCH: timer <= '0;
        S_BUSY: begin
          timer <= timer + TW'(1);
          if (done_rise) resp_signature <= eng_signature;
        end
        S_RESPOND, S_RECOVER: ptr <= idx_inc;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/ecdsa_sign_arbiter.md
# ecdsa_sign_arbiter

Round-robin scheduler that shares one `ecdsa_sign` engine among `N_REQ` requesters. It latches a requester's message and private key on grant, pulses the engine's `init`, and waits for a fresh `done`. It then returns the signature to the granted requester. A watchdog resets a hung engine and reports an error. The block sits between the requester logic (e.g. per-channel firmware mailboxes) and the engine's `init`/`master_reset`/`message`/`priv_key`/`my_signature`/`done` pins.

## Interface
- `N_REQ`, default 4: number of requesters, 2..16.
- `TIMEOUT_CYCLES`, default 1_000_000: maximum BUSY cycles before abort. Timer width is `$clog2(TIMEOUT_CYCLES+1)`.

- `clk`  in  1: single clock; everything is rising-edge.
- `master_reset_n`  in  1: reset, asynchronous, active-low.
- `req`  in  N_REQ: level request per requester.
- `req_message`  in  96*N_REQ: slot i is `[96*i +: 96]`.
- `req_priv_key`  in  256*N_REQ: slot i is `[256*i +: 256]`.
- `gnt`  out  N_REQ: one-hot; high for the requester being serviced.
- `resp_valid`  out  N_REQ: one-cycle completion pulse to the granted requester.
- `resp_error`  out  1: qualifies `resp_valid`; 1 = timeout abort.
- `resp_signature`  out  signature_t: valid while any `resp_valid` is high; holds its value otherwise.
- `busy`  out  1: high in any state other than IDLE.
- `eng_init`  out  1: one-cycle start pulse to the engine.
- `eng_reset`  out  1: active-high engine reset, drives the engine's `master_reset`.
- `eng_message`  out  96: latched message.
- `eng_priv_key`  out  256: latched key.
- `eng_signature`  in  signature_t: engine result.
- `eng_done`  in  1: engine done level.

## Operation
- **States:** IDLE, LAUNCH, BUSY, RESPOND, RECOVER.
- **IDLE**
  - If `req != 0`, select the first set bit scanning from `ptr` upward, wrapping modulo `N_REQ`.
  - Latch the selected index into `idx`, and latch its message and key into `eng_message`/`eng_priv_key`. Go to LAUNCH.
  - If `req == 0`, stay in IDLE.
- **LAUNCH**
  - `eng_init=1` for exactly this cycle. Clear the timer. Go to BUSY.
- **BUSY**
  - Increment the timer each cycle.
  - Completion requires a rising edge: `eng_done=1` this cycle and `done_q=0`, where `done_q` is the registered `eng_done`.
  - On completion, capture `eng_signature` into `resp_signature` and go to RESPOND.
  - Otherwise, if timer `== TIMEOUT_CYCLES-1`, go to RECOVER.
  - If both conditions occur in the same cycle, completion wins.
- **RESPOND**
  - `resp_valid[idx]=1`, `resp_error=0` for this one cycle.
  - Set `ptr <= (idx+1) mod N_REQ`. Go to IDLE.
- **RECOVER**
  - `eng_reset=1`, `resp_valid[idx]=1`, `resp_error=1` for this one cycle. `resp_signature` is unchanged.
  - Set `ptr <= (idx+1) mod N_REQ`. Go to IDLE.
- **Grant:** `gnt[idx]=1` in LAUNCH, BUSY, RESPOND and RECOVER; `gnt` is 0 in IDLE.
- **Requester rule:**
  - Hold `req` until `resp_valid` is sampled high, then deassert it on that same edge.
  - If `req` is still high in IDLE, it is treated as a new request.
  - `req_message`/`req_priv_key` may change once `gnt` is high.
- **Deasserted requests:** a `req` dropped during service has no effect; the operation completes and the response is still pulsed.
- **Engine reset:** `eng_reset = ~master_reset_n | (state==RECOVER)`, so the engine is held in reset throughout block reset.
- **Stale done:** a level `eng_done` left high from a prior operation never completes a new one; only a 0→1 transition in BUSY counts.

## Timing
- **Reset values:**
  - State IDLE; `ptr=0`; `idx=0`; timer 0; `done_q=0`.
  - `gnt`, `resp_valid`, `resp_error`, `busy`, `eng_init` all 0.
  - `resp_signature`, `eng_message`, `eng_priv_key` all 0.
  - `eng_reset` is 1 while reset is asserted.
- **Reset mid-operation:** reset asynchronously forces all of the above. No `resp_valid` is issued for the aborted request.
- **Latency:**
  - `req` sampled in IDLE at edge 0; `gnt` and `eng_init` are high in cycle 1 (LAUNCH).
  - BUSY starts at cycle 2.
  - Engine done edge seen at cycle k gives `resp_valid` at cycle k+1.
  - `busy` drops at cycle k+2.
  - Minimum request-to-response is 4 cycles.
- **Back-to-back:** a new grant is possible on the first IDLE cycle after RESPOND/RECOVER. No bubble is required beyond that IDLE cycle.
- **Timeout:** RECOVER occurs in BUSY cycle number `TIMEOUT_CYCLES` (1-based).
- **Outputs:** all outputs are registered or decoded from registered state only. There is no combinational path from `req` to `gnt`.

## Test plan
- **Single request:** `N_REQ=4`, `req=4'b0100`, message `96'hA5…`, engine model completes after 50 cycles with r=1, s=2.
  - `gnt=0100` from cycle 1.
  - `eng_init` pulses exactly once with the latched message.
  - `resp_valid=0100`, `resp_error=0`, signature (1,2) appear one cycle after the done edge.
- **Fairness:** `req=4'b1111` held continuously, each requester re-raising `req` after its response. Grants must be served in order 0,1,2,3,0,1; no requester is served twice before the others.
- **Timeout:** `TIMEOUT_CYCLES=16`, engine never asserts done.
  - RECOVER occurs after 16 BUSY cycles.
  - `eng_reset` is high for 1 cycle, together with `resp_valid[idx]=1` and `resp_error=1`.
  - `ptr` advances.
- **Stale done:** `eng_done` is tied high from before LAUNCH, then dropped at cycle 5 and re-raised at cycle 9. Completion must occur only at cycle 9.
- **Reset mid-BUSY:** pull `master_reset_n` low at cycle 20 of an operation.
  - Outputs take their reset values immediately.
  - `eng_reset=1` throughout reset.
  - After release, a new `req=0001` is served normally starting from `ptr=0`.
- **Simultaneous events:** done edge and timeout land in the same cycle. The result must be RESPOND with `resp_error=0`.
